// File: rtl/wb_chunk_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_chunk_pipe: double-buffered word-to-chunk reader, Wishbone B4 pipelined |
// | Rev 1.0 - initial release                                                  |
// +--------------------------------------------------------------------------+
module wb_chunk_pipe #(
    parameter int WIDTH     = 48,
    parameter int CHUNK     = 8,
    parameter int NCHUNK    = (WIDTH + CHUNK - 1) / CHUNK,
    parameter int CBITS     = 3,
    parameter int MSB_FIRST = 0,
    parameter int PREFETCH  = 1,
    parameter int DELAY     = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    output logic             stall_o,
    output logic             ack_o,
    input  logic [CHUNK-1:0] dat_i,
    output logic [CHUNK-1:0] dat_o,
    output logic             last_o,
    output logic             fetch_o,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] value_i,
    output logic [1:0]       level_o
);

    localparam int              PADW     = NCHUNK * CHUNK;
    localparam logic [CBITS-1:0] LAST_IDX = CBITS'(NCHUNK - 1);

    if ((2 ** CBITS) < NCHUNK) begin : g_cbits_check
        $error("wb_chunk_pipe: CBITS too small for NCHUNK");
    end
    // DELAY only shapes simulation timing elsewhere; it has no effect on this logic.
    if (DELAY < 0) begin : g_delay_check
        $error("wb_chunk_pipe: DELAY must be non-negative");
    end

    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] spare_q, spare_d;
    logic             active_valid_q, active_valid_d;
    logic             spare_valid_q, spare_valid_d;
    logic [CBITS-1:0] count_q, count_d;
    logic             ack_q, ack_d;
    logic             last_q, last_d;
    logic [CHUNK-1:0] dat_q, dat_d;
    logic             fetch_q, fetch_d;

    logic             w_accept;
    logic             w_final;
    logic             w_handshake;
    logic             w_slot_free;
    logic [CBITS-1:0] w_sel;
    logic [PADW-1:0]  w_padded;
    logic [CHUNK-1:0] w_chunk;
    logic             w_unused_inputs;

    assign w_unused_inputs = ^{we_i, dat_i};

    assign w_accept    = cyc_i & stb_i & active_valid_q;
    assign w_final     = (count_q == LAST_IDX);
    assign w_handshake = fetch_q & ready_i;
    assign w_slot_free = !active_valid_q || ((PREFETCH != 0) && !spare_valid_q);
    assign w_sel       = (MSB_FIRST != 0) ? (LAST_IDX - count_q) : count_q;

    always_comb begin
        w_padded             = '0;
        w_padded[WIDTH-1:0]  = active_q;
    end

    assign w_chunk = w_padded[int'(w_sel) * CHUNK +: CHUNK];

    always_comb begin
        active_d       = active_q;
        spare_d        = spare_q;
        active_valid_d = active_valid_q;
        spare_valid_d  = spare_valid_q;
        count_d        = count_q;
        ack_d          = 1'b0;
        last_d         = 1'b0;
        dat_d          = dat_q;
        fetch_d        = fetch_q;

        if (w_accept) begin
            ack_d  = 1'b1;
            last_d = w_final;
            dat_d  = w_chunk;
            if (w_final) begin
                count_d = '0;
                // Promote the prefetched word on the same edge so reads never bubble.
                if (spare_valid_q) begin
                    active_d      = spare_q;
                    spare_valid_d = 1'b0;
                end else begin
                    active_valid_d = 1'b0;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        // Capture decision looks at the slot state after this edge's read effects.
        if (w_handshake) begin
            fetch_d = 1'b0;
            if (!active_valid_d) begin
                active_d       = value_i;
                active_valid_d = 1'b1;
                count_d        = '0;
            end else if (PREFETCH != 0) begin
                spare_d       = value_i;
                spare_valid_d = 1'b1;
            end
        end else if (!fetch_q && cyc_i && w_slot_free) begin
            fetch_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q       <= '0;
            spare_q        <= '0;
            active_valid_q <= 1'b0;
            spare_valid_q  <= 1'b0;
            count_q        <= '0;
            ack_q          <= 1'b0;
            last_q         <= 1'b0;
            dat_q          <= '0;
            fetch_q        <= 1'b0;
        end else begin
            active_q       <= active_d;
            spare_q        <= spare_d;
            active_valid_q <= active_valid_d;
            spare_valid_q  <= spare_valid_d;
            count_q        <= count_d;
            ack_q          <= ack_d;
            last_q         <= last_d;
            dat_q          <= dat_d;
            fetch_q        <= fetch_d;
        end
    end

    assign stall_o = !active_valid_q;
    assign ack_o   = ack_q;
    assign last_o  = last_q;
    assign dat_o   = dat_q;
    assign fetch_o = fetch_q;
    assign level_o = {1'b0, active_valid_q} + {1'b0, spare_valid_q};

endmodule
`default_nettype wire

// File: tb/tb_wb_chunk_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_chunk_pipe: directed bench for three wb_chunk_pipe configurations    |
// | Rev 1.0 - initial release                                                  |
// +--------------------------------------------------------------------------+
module tb_wb_chunk_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc   [3];
    logic        stb   [3];
    logic        ready [3];
    logic        fetch [3];
    logic        ack   [3];
    logic        last  [3];
    logic        stall [3];
    logic [7:0]  dat   [3];
    logic [1:0]  lvl   [3];
    logic [47:0] val   [3];

    logic [47:0] words [3][8];
    int          rdly  [3];

    int total  = 0;
    int passed = 0;

    logic [7:0] got_dat  [$];
    logic       got_last [$];
    logic [1:0] got_lvl  [$];
    int         stall_seen;
    int         ack_err;

    always #5 clk = ~clk;

    // A: 48-bit LSB-first prefetch, B: 48-bit MSB-first, C: 20-bit single buffer
    wb_chunk_pipe #(.WIDTH(48), .CHUNK(8), .CBITS(3), .MSB_FIRST(0), .PREFETCH(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(1'b0),
        .stall_o(stall[0]), .ack_o(ack[0]), .dat_i(8'h00), .dat_o(dat[0]), .last_o(last[0]),
        .fetch_o(fetch[0]), .ready_i(ready[0]), .value_i(val[0]), .level_o(lvl[0]));

    wb_chunk_pipe #(.WIDTH(48), .CHUNK(8), .CBITS(3), .MSB_FIRST(1), .PREFETCH(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(1'b0),
        .stall_o(stall[1]), .ack_o(ack[1]), .dat_i(8'h00), .dat_o(dat[1]), .last_o(last[1]),
        .fetch_o(fetch[1]), .ready_i(ready[1]), .value_i(val[1]), .level_o(lvl[1]));

    wb_chunk_pipe #(.WIDTH(20), .CHUNK(8), .CBITS(2), .MSB_FIRST(0), .PREFETCH(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(1'b0),
        .stall_o(stall[2]), .ack_o(ack[2]), .dat_i(8'h00), .dat_o(dat[2]), .last_o(last[2]),
        .fetch_o(fetch[2]), .ready_i(ready[2]), .value_i(val[2][19:0]), .level_o(lvl[2]));

    // Upstream model: answers fetch_o with ready_i after rdly observed cycles.
    initial begin
        int cnt [3];
        int ptr [3];
        for (int g = 0; g < 3; g++) begin
            cnt[g] = 0; ptr[g] = 0; ready[g] = 1'b0; val[g] = '0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (!rst_n) begin
                    ready[g] = 1'b0; cnt[g] = 0;
                end else if (ready[g]) begin
                    ready[g] = 1'b0; ptr[g]++; cnt[g] = 0;
                end else if (fetch[g]) begin
                    cnt[g]++;
                    if (cnt[g] >= rdly[g]) begin
                        ready[g] = 1'b1;
                        val[g]   = words[g][ptr[g] % 8];
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic stream(input int g, input int n);
        int  acc, acks, cycles;
        bit  prev_acc;
        got_dat.delete(); got_last.delete(); got_lvl.delete();
        stall_seen = 0; ack_err = 0;
        acc = 0; acks = 0; cycles = 0; prev_acc = 1'b0;
        cyc[g] = 1'b1;
        while ((acks < n) && (cycles < 200)) begin
            @(negedge clk);
            cycles++;
            if (ack[g] !== prev_acc) ack_err++;
            if (ack[g] === 1'b1) begin
                acks++;
                got_dat.push_back(dat[g]);
                got_last.push_back(last[g]);
                got_lvl.push_back(lvl[g]);
            end
            if (acc < n) begin
                stb[g] = 1'b1;
                if (stall[g]) stall_seen++;
                else acc++;
                prev_acc = !stall[g];
            end else begin
                stb[g]   = 1'b0;
                prev_acc = 1'b0;
            end
        end
        stb[g] = 1'b0;
        check("ack_count", acks, n);
    endtask

    function automatic logic [127:0] pack_dat();
        logic [127:0] r = '0;
        foreach (got_dat[i]) r = {r[119:0], got_dat[i]};
        return r;
    endfunction

    function automatic logic [127:0] pack_last();
        logic [127:0] r = '0;
        foreach (got_last[i]) r = {r[126:0], got_last[i]};
        return r;
    endfunction

    initial begin
        logic [7:0]   exp_a [12];
        logic [127:0] lv;

        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            cyc[g] = 1'b0; stb[g] = 1'b0; rdly[g] = 2;
            for (int w = 0; w < 8; w++) words[g][w] = '0;
        end
        words[0][0] = 48'h0605_0403_0201;
        words[0][1] = 48'h0C0B_0A09_0807;
        words[0][2] = 48'h1211_100F_0E0D;
        words[0][3] = 48'h1817_1615_1413;
        words[0][4] = 48'h1E1D_1C1B_1A19;
        for (int w = 0; w < 8; w++) words[1][w] = words[0][w];
        words[2][0] = 48'h0_ABCDE;
        words[2][1] = 48'h0_12345;
        words[2][2] = 48'h0_6789A;
        words[2][3] = 48'h0_FEDCB;
        exp_a = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};

        repeat (3) @(negedge clk);
        check("rst_ack",   ack[0],   1'b0);
        check("rst_last",  last[0],  1'b0);
        check("rst_fetch", fetch[0], 1'b0);
        check("rst_dat",   dat[0],   8'h00);
        check("rst_level", lvl[0],   2'd0);
        check("rst_stall", stall[0], 1'b1);

        for (int g = 0; g < 3; g++) cyc[g] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("preload_level_a", lvl[0],   2'd2);
        check("preload_level_b", lvl[1],   2'd2);
        check("preload_level_c", lvl[2],   2'd1);
        check("full_no_fetch",   fetch[0], 1'b0);
        check("full_no_stall",   stall[0], 1'b0);

        // A: 12 back-to-back reads across two prefetched words
        stream(0, 12);
        for (int i = 0; i < 12; i++)
            check($sformatf("a_dat%0d", i), (i < got_dat.size()) ? got_dat[i] : 8'hxx, exp_a[i]);
        check("a_last", pack_last(), 128'h041);
        lv = '0;
        foreach (got_lvl[i]) lv = {lv[125:0], got_lvl[i]};
        check("a_level_trace", lv, 128'hAA95A9);
        check("a_no_stall", stall_seen, 0);
        check("a_ack_stream", ack_err, 0);
        repeat (6) @(negedge clk);
        check("a_refill_level", lvl[0], 2'd2);

        // B: MSB-first
        stream(1, 6);
        check("b_dat", pack_dat(), 128'h0605_0403_0201);
        check("b_last", pack_last(), 128'b000001);

        // C: 20-bit words, padded top chunk, single buffer
        stream(2, 12);
        check("c_dat", pack_dat(), 128'hDEBC0A_452301_9A7806_CBED0F);
        check("c_last", pack_last(), 128'h249);
        check("c_stall_cycles", stall_seen, 9);
        check("c_no_ack_stalled", ack_err, 0);

        // A: drop cyc mid-word, then resume from the retained position
        stream(0, 3);
        check("a_part1", pack_dat(), 128'h0D0E0F);
        check("a_part1_last", pack_last(), 128'b000);
        cyc[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("cyc_low_ack", ack[0], 1'b0);
        check("cyc_low_level", lvl[0], 2'd2);
        stream(0, 3);
        check("a_part2", pack_dat(), 128'h101112);
        check("a_part2_last", pack_last(), 128'b001);

        // Asynchronous reset while a fetch is outstanding
        rdly[0] = 6;
        repeat (2) @(negedge clk);
        check("pending_fetch", fetch[0], 1'b1);
        check("pending_level", lvl[0], 2'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_fetch", fetch[0], 1'b0);
        check("async_level", lvl[0],   2'd0);
        check("async_stall", stall[0], 1'b1);
        check("async_ack",   ack[0],   1'b0);
        check("async_dat",   dat[0],   8'h00);
        repeat (2) @(negedge clk);
        rdly[0] = 2;
        rst_n   = 1'b1;
        stream(0, 1);
        check("post_rst_stall", stall_seen, 2);
        check("post_rst_dat", pack_dat(), 128'h19);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_chunk_pipe.md
Name: wb_chunk_pipe

Overview:
Parametrised successor to the classic-cycle chunker. It fetches WIDTH-bit words from an upstream source over a fetch/ready handshake and serves them as CHUNK-bit reads on a Wishbone B4 pipelined slave port. A two-word buffer (active + spare) prefetches the next word so reads stream at one chunk per cycle across word boundaries. Chunk order is selectable, and the final chunk of each word is flagged. It sits between capture/correlator result registers and the SPI/Wishbone readout bus.

Parameters:
WIDTH, 48, bits per upstream word
CHUNK, 8, bits per bus read (dat_o width)
NCHUNK, (WIDTH+CHUNK-1)/CHUNK, chunks per word; the top chunk is zero-padded when WIDTH is not a multiple of CHUNK
CBITS, 3, chunk-counter width; must satisfy 2**CBITS >= NCHUNK
MSB_FIRST, 0, 0 = least-significant chunk first, 1 = most-significant chunk first
PREFETCH, 1, 1 = spare slot enabled (double buffer), 0 = single word, fetched only when empty
DELAY, 3, simulation-only non-blocking assignment delay

Ports:
clk_i  in  1  system clock, rising edge
rst_ni  in  1  asynchronous active-low reset
cyc_i  in  1  bus cycle
stb_i  in  1  read strobe
we_i  in  1  ignored
stall_o  out  1  request cannot be accepted this cycle
ack_o  out  1  one-cycle acknowledge per accepted request
dat_i  in  CHUNK  ignored
dat_o  out  CHUNK  read chunk, valid while ack_o
last_o  out  1  high with ack_o when the chunk is the final chunk of its word
fetch_o  out  1  request a word from upstream
ready_i  in  1  upstream word present on value_i
value_i  in  WIDTH  upstream word
level_o  out  2  words held (0..2)

Behaviour:
- Reset (rst_ni low, asynchronous): ack_o=0, last_o=0, fetch_o=0, dat_o=0, level_o=0, both slots invalid, count=0, stall_o=1.
- stall_o = !active_valid (combinational from registers only).
- Accept = cyc_i & stb_i & !stall_o. On accept:
  - ack_o=1 at the next edge.
  - dat_o is registered with the selected chunk:
    - LSB-first: chunk k = word[k*CHUNK +: CHUNK].
    - MSB-first: chunk index NCHUNK-1-k.
  - last_o=1 when k == NCHUNK-1.
  - count increments, or wraps to 0 on the final chunk.
- ack_o/last_o are low in any cycle that follows a non-accept. Back-to-back accepts give continuous ack_o, one per cycle.
- Final-chunk accept:
  - If spare is valid: spare moves to active on the same edge and count=0; stall_o stays low (no bubble).
  - Otherwise: active_valid is cleared.
- Fetch, with cyc_i high:
  - fetch_o is set when a slot is free: active empty, or (PREFETCH=1 and spare empty).
  - fetch_o is held until ready_i.
  - On fetch_o & ready_i: value_i is captured into active if active is empty after this edge's accept effects, else into spare. fetch_o clears at that edge.
  - The minimum gap between handshakes is one cycle.
- Simultaneous final-chunk accept and handshake, spare empty: the fetched word goes directly into active, count=0, with no stall cycle.
- Both slots full: fetch_o stays low. An outstanding fetch can occur only when a slot is free, so there is no overflow.
- cyc_i low:
  - No accepts; ack_o is low on the next cycle.
  - A pending fetch_o is not withdrawn; the handshake completes normally.
  - No new fetch_o is raised.
  - A partially read word and its count are retained for the next cycle.
- level_o = active_valid + spare_valid. When PREFETCH=0, spare is never used and level_o ≤ 1.
- stb_i while stalled: no ack is generated; the master must retry.
- Reset mid-word discards all buffered data.

Test Plan:
- WIDTH=48, CHUNK=8, LSB-first. Upstream supplies 0x0605_0403_0201 with ready_i 2 cycles after fetch_o; master issues 6 pipelined reads → dat_o 01,02,03,04,05,06 on consecutive acks; last_o only on 06.
- Same configuration with MSB_FIRST=1 → dat_o 06,05,04,03,02,01; last_o on 01.
- WIDTH=20, CHUNK=8, value_i=0xABCDE, LSB-first → dat_o DE, BC, 0A (top chunk padded); NCHUNK=3.
- PREFETCH=1, two words preloaded (level_o=2). 12 back-to-back reads → 12 consecutive acks with stall_o never high; level_o drops to 1 at word 1's last chunk, then a fetch refills it.
- PREFETCH=0, 12 reads → stall_o high for at least 2 cycles between words; no ack while stalled.
- Drop cyc_i after chunk 3 of 6; pulse rst_ni low asynchronously mid-fetch → outputs go to reset values immediately; after release, the first read stalls until a new fetch completes.
